// File: rtl/fpioa_v2.sv
// rtl/fpioa_v2.sv - pad/peripheral crossbar with pad synchronisers and external-line interrupts; optional macro FPIOA_ELI_FILTER_EN
module fpioa_v2 #(
    parameter int PORT_NUM = 32,
    parameter int PO_NUM   = 32,
    parameter int PI_NUM   = 32,
    parameter int ELI_NUM  = 4,
    parameter int ELI_BASE = 4,
    parameter int FLT_W    = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [9:0]          waddr_i,
    input  logic [31:0]         data_i,
    input  logic [3:0]          sel_i,
    input  logic                we_i,
    input  logic [9:0]          raddr_i,
    input  logic                rd_i,
    output logic [31:0]         data_o,
    input  logic [PO_NUM-1:0]   perips_ot_i,
    input  logic [PO_NUM-1:0]   perips_oe_i,
    output logic [PI_NUM-1:0]   perips_in_o,
    input  logic [PORT_NUM-1:0] fpioa_in_i,
    output logic [PORT_NUM-1:0] fpioa_ot_o,
    output logic [PORT_NUM-1:0] fpioa_oe_o,
    output logic [ELI_NUM-1:0]  irq_eli_o,
    output logic                irq_o
);
    localparam int OSW = (PO_NUM > 1) ? $clog2(PO_NUM) : 1;
    localparam int ISW = (PORT_NUM > 1) ? $clog2(PORT_NUM) : 1;

    logic [PORT_NUM-1:0]  opt_q, md0_q, md1_q, sy1_q, sy2_q;
    logic [4*ELI_NUM-1:0] elimd_q;
    logic [ELI_NUM-1:0]   pend_q, ie_q, es1_q, es2_q, fd_q, f, trig, w1c;
    logic [OSW-1:0]       osel_q [PORT_NUM];
    logic [ISW-1:0]       isel_q [PI_NUM];
    logic [31:0]          data_q, rdata, wmask;
    logic [2**OSW-1:0]    po_ot_ext, po_oe_ext;
    logic [2**ISW-1:0]    pad_ext;
    logic                 unused_addr_lsb;

    assign unused_addr_lsb = ^{waddr_i[1:0], raddr_i[1:0]};

    function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] d, input logic [31:0] m);
        return (o & ~m) | (d & m);
    endfunction

    // byte-enable mask shared by every writable register
    always_comb wmask = {{8{sel_i[3]}}, {8{sel_i[2]}}, {8{sel_i[1]}}, {8{sel_i[0]}}};

    // configuration registers (word-decoded on waddr_i[9:2])
    always_ff @(posedge clk) begin
        if (rst) begin
            opt_q   <= '0;
            md0_q   <= '0;
            md1_q   <= '0;
            elimd_q <= '0;
            ie_q    <= '0;
            for (int p = 0; p < PORT_NUM; p++) osel_q[p] <= '0;
            for (int q = 0; q < PI_NUM; q++) isel_q[q] <= '0;
        end else if (we_i) begin
            case (waddr_i[9:2])
                8'd1: opt_q   <= PORT_NUM'(merge(32'(opt_q), data_i, wmask));
                8'd2: md0_q   <= PORT_NUM'(merge(32'(md0_q), data_i, wmask));
                8'd3: md1_q   <= PORT_NUM'(merge(32'(md1_q), data_i, wmask));
                8'd4: elimd_q <= (4*ELI_NUM)'(merge(32'(elimd_q), data_i, wmask));
                8'd6: ie_q    <= ELI_NUM'(merge(32'(ie_q), data_i, wmask));
                default: ;
            endcase
            for (int p = 0; p < PORT_NUM; p++)
                if (waddr_i[9:2] == 8'(64 + p)) osel_q[p] <= OSW'(merge(32'(osel_q[p]), data_i, wmask));
            for (int q = 0; q < PI_NUM; q++)
                if (waddr_i[9:2] == 8'(128 + q)) isel_q[q] <= ISW'(merge(32'(isel_q[q]), data_i, wmask));
        end
    end

`ifdef FPIOA_ELI_FILTER_EN
    logic [FLT_W-1:0]   flt_q [ELI_NUM];
    logic [FLT_W-1:0]   cnt_q [ELI_NUM];
    logic [ELI_NUM-1:0] ff_q;

    // glitch filter: the level only moves after s has differed for FLT+1 consecutive cycles
    always_ff @(posedge clk) begin
        if (rst) begin
            ff_q <= '0;
            for (int k = 0; k < ELI_NUM; k++) begin
                flt_q[k] <= '0;
                cnt_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < ELI_NUM; k++) begin
                if (we_i && waddr_i[9:2] == 8'(8 + k))
                    flt_q[k] <= FLT_W'(merge(32'(flt_q[k]), data_i, wmask));
                if (es2_q[k] == ff_q[k]) begin
                    cnt_q[k] <= '0;
                end else if (cnt_q[k] == flt_q[k]) begin
                    ff_q[k]  <= es2_q[k];
                    cnt_q[k] <= '0;
                end else begin
                    cnt_q[k] <= cnt_q[k] + 1'b1;
                end
            end
        end
    end
    assign f = ff_q;
`else
    localparam int unused_flt_w = FLT_W;
    assign f = es2_q;
`endif

    // trigger conditions per channel, MD nibble = {fall, rise, low, high}
    always_comb begin
        trig = '0;
        for (int k = 0; k < ELI_NUM; k++)
            trig[k] = (elimd_q[4*k]   &  f[k])
                    | (elimd_q[4*k+1] & ~f[k])
                    | (elimd_q[4*k+2] &  f[k] & ~fd_q[k])
                    | (elimd_q[4*k+3] & ~f[k] &  fd_q[k]);
    end

    // write-1-to-clear request for the pending register
    always_comb w1c = (we_i && waddr_i[9:2] == 8'd5) ? ELI_NUM'(data_i & wmask) : '0;

    // pad and ELI synchronisers, delayed filter level and sticky pending (set beats clear)
    always_ff @(posedge clk) begin
        if (rst) begin
            sy1_q  <= '0;
            sy2_q  <= '0;
            es1_q  <= '0;
            es2_q  <= '0;
            fd_q   <= '0;
            pend_q <= '0;
        end else begin
            sy1_q  <= fpioa_in_i;
            sy2_q  <= sy1_q;
            es1_q  <= perips_in_o[ELI_BASE +: ELI_NUM];
            es2_q  <= es1_q;
            fd_q   <= f;
            pend_q <= (pend_q & ~w1c) | trig;
        end
    end

    // read mux; sampled only on rd_i so a same-cycle write shows the old value
    always_comb begin
        rdata = '0;
        case (raddr_i[9:2])
            8'd0: rdata = 32'(sy2_q);
            8'd1: rdata = 32'(opt_q);
            8'd2: rdata = 32'(md0_q);
            8'd3: rdata = 32'(md1_q);
            8'd4: rdata = 32'(elimd_q);
            8'd5: rdata = 32'(pend_q);
            8'd6: rdata = 32'(ie_q);
            default: ;
        endcase
`ifdef FPIOA_ELI_FILTER_EN
        for (int k = 0; k < ELI_NUM; k++)
            if (raddr_i[9:2] == 8'(8 + k)) rdata = 32'(flt_q[k]);
`endif
        for (int p = 0; p < PORT_NUM; p++)
            if (raddr_i[9:2] == 8'(64 + p)) rdata = 32'(osel_q[p]);
        for (int q = 0; q < PI_NUM; q++)
            if (raddr_i[9:2] == 8'(128 + q)) rdata = 32'(isel_q[q]);
    end

    // registered read data, held while rd_i is low
    always_ff @(posedge clk) begin
        if (rst) data_q <= '0;
        else if (rd_i) data_q <= rdata;
    end
    assign data_o = data_q;

    // output crossbar: slot 0 is normal IO, out-of-range slots park the pad as input
    always_comb begin
        po_ot_ext = '0;
        po_oe_ext = '0;
        po_ot_ext[PO_NUM-1:0] = perips_ot_i;
        po_oe_ext[PO_NUM-1:0] = perips_oe_i;
        fpioa_ot_o = '0;
        fpioa_oe_o = '0;
        for (int p = 0; p < PORT_NUM; p++) begin
            if (osel_q[p] == '0) begin
                case ({md1_q[p], md0_q[p]})
                    2'b10: begin fpioa_oe_o[p] = 1'b1;      fpioa_ot_o[p] = opt_q[p]; end
                    2'b11: begin fpioa_oe_o[p] = ~opt_q[p]; fpioa_ot_o[p] = 1'b0;     end
                    default: ;
                endcase
            end else if (32'(osel_q[p]) < PO_NUM) begin
                fpioa_ot_o[p] = po_ot_ext[osel_q[p]];
                fpioa_oe_o[p] = po_oe_ext[osel_q[p]];
            end
        end
    end

    // input crossbar, unsynchronised; out-of-range pad selects read 0
    always_comb begin
        pad_ext = '0;
        pad_ext[PORT_NUM-1:0] = fpioa_in_i;
        perips_in_o = '0;
        for (int q = 0; q < PI_NUM; q++)
            perips_in_o[q] = (32'(isel_q[q]) < PORT_NUM) ? pad_ext[isel_q[q]] : 1'b0;
    end

    assign irq_eli_o = pend_q & ie_q;
    assign irq_o     = |irq_eli_o;
endmodule

// File: tb/tb_fpioa_v2.sv
// tb/tb_fpioa_v2.sv - scoreboard bench for fpioa_v2
module tb_fpioa_v2;
    localparam int PORT_NUM = 32;
    localparam int PO_NUM   = 24;
    localparam int PI_NUM   = 32;
    localparam int ELI_NUM  = 4;

    localparam int K_RD = 0, K_DO = 1, K_OE = 2, K_OT = 3, K_PIN = 4, K_IRQ = 5;

`ifdef FPIOA_ELI_FILTER_EN
    localparam int PRE = 5;
    localparam logic [31:0] SHORT_EXP = 32'h0;
    localparam logic [31:0] FLT_EXP = 32'h3;
`else
    localparam int PRE = 1;
    localparam logic [31:0] SHORT_EXP = 32'h1;
    localparam logic [31:0] FLT_EXP = 32'h0;
`endif

    logic                clk, rst;
    logic [9:0]          waddr, raddr;
    logic [31:0]         wdata, data_o;
    logic [3:0]          sel;
    logic                we, rd_i, rd_seen, chk_flag;
    logic [PO_NUM-1:0]   p_ot, p_oe;
    logic [PI_NUM-1:0]   p_in;
    logic [PORT_NUM-1:0] pad_in, pad_ot, pad_oe;
    logic [ELI_NUM-1:0]  irq_eli;
    logic                irq;

    typedef struct {
        string       name;
        int          kind;
        logic [31:0] exp;
    } exp_t;
    exp_t sb[$];
    int n_cmp = 0;
    int n_bad = 0;

    fpioa_v2 #(.PORT_NUM(PORT_NUM), .PO_NUM(PO_NUM), .PI_NUM(PI_NUM),
               .ELI_NUM(ELI_NUM), .ELI_BASE(4), .FLT_W(8)) dut (
        .clk(clk), .rst(rst), .waddr_i(waddr), .data_i(wdata), .sel_i(sel), .we_i(we),
        .raddr_i(raddr), .rd_i(rd_i), .data_o(data_o),
        .perips_ot_i(p_ot), .perips_oe_i(p_oe), .perips_in_o(p_in),
        .fpioa_in_i(pad_in), .fpioa_ot_o(pad_ot), .fpioa_oe_o(pad_oe),
        .irq_eli_o(irq_eli), .irq_o(irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) rd_seen <= rd_i;

    function automatic logic [31:0] observe(input int kind);
        case (kind)
            K_RD, K_DO: return data_o;
            K_OE:       return pad_oe;
            K_OT:       return pad_ot;
            K_PIN:      return p_in;
            default:    return {27'b0, irq_eli, irq};
        endcase
    endfunction

    // monitor: pops the head entry whenever the matching output is presented
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            if ((sb[0].kind == K_RD) ? rd_seen : chk_flag) begin
                exp_t e;
                logic [31:0] act;
                e = sb.pop_front();
                act = observe(e.kind);
                n_cmp++;
                if (act !== e.exp) begin
                    n_bad++;
                    $display("FAIL %s: got %h, expected %h", e.name, act, e.exp);
                end
            end
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic drained(input string name);
        if (sb.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s: %0d expected entries never consumed, required 0", name, sb.size());
            sb.delete();
        end
    endtask

    task automatic wr(input logic [9:0] a, input logic [31:0] d, input logic [3:0] s = 4'hF);
        waddr = a; wdata = d; sel = s; we = 1'b1;
        tick();
        we = 1'b0;
    endtask

    task automatic rd(input logic [9:0] a, input string name, input logic [31:0] exp);
        exp_t e;
        e.name = name; e.kind = K_RD; e.exp = exp;
        sb.push_back(e);
        raddr = a; rd_i = 1'b1;
        tick();
        rd_i = 1'b0;
        drained(name);
    endtask

    task automatic chk(input int kind, input string name, input logic [31:0] exp);
        exp_t e;
        e.name = name; e.kind = kind; e.exp = exp;
        sb.push_back(e);
        chk_flag = 1'b1;
        tick();
        chk_flag = 1'b0;
        drained(name);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        rst = 1'b1; waddr = '0; raddr = '0; wdata = '0; sel = 4'hF; we = 1'b0; rd_i = 1'b0;
        chk_flag = 1'b0; p_ot = '0; p_oe = '0; pad_in = '0;
        tick(3);
        rst = 1'b0;

        chk(K_DO,  "reset_data_o", 32'h0);
        chk(K_OE,  "reset_oe", 32'h0);
        chk(K_IRQ, "reset_irq", 32'h0);
        rd(10'h004, "reset_opt", 32'h0);

        wr(10'h00C, 32'h8);
        wr(10'h004, 32'h8);
        chk(K_OE, "pp_oe", 32'h8);
        chk(K_OT, "pp_ot_hi", 32'h8);
        wr(10'h004, 32'h0);
        chk(K_OT, "pp_ot_lo", 32'h0);
        wr(10'h004, 32'hFFFF_FFFF, 4'b0010);
        rd(10'h004, "byte_enable", 32'h0000_FF00);
        wr(10'h004, 32'h0);

        wr(10'h00C, 32'h28);
        wr(10'h008, 32'h20);
        wr(10'h004, 32'h20);
        chk(K_OE, "od_opt1_oe", 32'h08);
        wr(10'h004, 32'h0);
        chk(K_OE, "od_opt0_oe", 32'h28);
        chk(K_OT, "od_opt0_ot", 32'h0);

        wr(10'h108, 32'd7);
        p_oe = 24'h80; p_ot = 24'h80;
        chk(K_OT, "route_ot_hi", 32'h4);
        chk(K_OE, "route_oe", 32'h2C);
        p_ot = '0;
        chk(K_OT, "route_ot_lo", 32'h0);
        wr(10'h108, 32'd24);
        chk(K_OE, "route_oob_oe", 32'h28);
        rd(10'h108, "osel2_rb", 32'd24);

        wr(10'h200, 32'd9);
        pad_in = 32'h200;
        chk(K_PIN, "isel_hi", 32'h1);
        pad_in = 32'h0;
        chk(K_PIN, "isel_lo", 32'h0);

        pad_in = 32'hA5;
        tick();
        rd(10'h000, "din_1cyc", 32'h0);
        rd(10'h000, "din_2cyc", 32'hA5);
        pad_in = 32'h0;

        wr(10'h210, 32'd11);
        wr(10'h020, 32'd3);
        tick(6);
        wr(10'h010, 32'h4);
        wr(10'h018, 32'h1);
        rd(10'h020, "flt0_rb", FLT_EXP);
        rd(10'h014, "pend_idle", 32'h0);

        pad_in[11] = 1'b1;
        tick(3);
        pad_in[11] = 1'b0;
        tick(8);
        rd(10'h014, "short_pulse", SHORT_EXP);
        wr(10'h014, 32'h1);
        rd(10'h014, "short_clear", 32'h0);

        pad_in[11] = 1'b1;
        tick(PRE);
        chk(K_IRQ, "pulse_early", 32'h0);
        pad_in[11] = 1'b0;
        chk(K_IRQ, "pulse_exact", 32'h3);
        tick(10);
        wr(10'h014, 32'h1);
        rd(10'h014, "pulse_clear", 32'h0);

        wr(10'h010, 32'h14);
        pad_in[0] = 1'b1;
        tick(10);
        rd(10'h014, "level_pend", 32'h2);
        wr(10'h014, 32'h2);
        rd(10'h014, "w1c_race", 32'h2);
        chk(K_IRQ, "ie_mask", 32'h0);
        wr(10'h018, 32'h3);
        chk(K_IRQ, "ie_unmask", 32'h5);

        waddr = 10'h018; wdata = 32'h0; sel = 4'hF; we = 1'b1;
        raddr = 10'h018; rd_i = 1'b1;
        e.name = "rw_same_old"; e.kind = K_RD; e.exp = 32'h3;
        sb.push_back(e);
        tick();
        we = 1'b0; rd_i = 1'b0;
        drained("rw_same_old");
        rd(10'h018, "rw_same_new", 32'h0);
        wr(10'h018, 32'h3);

        pad_in[0] = 1'b0;
        tick(10);
        rd(10'h014, "sticky", 32'h2);
        chk(K_IRQ, "sticky_irq", 32'h5);
        wr(10'h014, 32'h2);
        rd(10'h014, "clear_after", 32'h0);
        chk(K_IRQ, "clear_irq", 32'h0);

        pad_in[11] = 1'b1;
        tick(3);
        rd(10'h00C, "md1_pre_rst", 32'h28);
        chk(K_DO, "data_hold", 32'h28);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        pad_in[11] = 1'b0;
        chk(K_DO,  "rst_data_o", 32'h0);
        chk(K_OE,  "rst_oe", 32'h0);
        chk(K_IRQ, "rst_irq", 32'h0);
        rd(10'h014, "rst_pend", 32'h0);
        rd(10'h00C, "rst_md1", 32'h0);
        rd(10'h020, "rst_flt", 32'h0);
        rd(10'h210, "rst_isel", 32'h0);
        rd(10'h000, "rst_din", 32'h0);

        tick(2);
        drained("final");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
